// File: rtl/fft_r2_iter_if.sv
// Valid/ready streams of fft_r2_iter: time-domain samples in, frequency bins out.
interface fft_r2_iter_if #(
  parameter int N_LOG2 = 4,
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic [N_LOG2-1:0]        out_idx;
  logic                     out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT, one butterfly per clock over a register-array buffer.
// Optional FFT_STAGE_SCALE_EN halves every butterfly result (overall 1/N scaling).
module fft_r2_iter #(
  parameter int N_LOG2 = 4,
  parameter int DATA_W = 32,
  parameter int TW_W   = 18
) (
  input  logic         clk,
  input  logic         rst,
  fft_r2_iter_if.slave bus,
  output logic         busy
);
  localparam int  N      = 1 << N_LOG2;
  localparam int  HALF_N = N / 2;
  localparam int  S_W    = $clog2(N_LOG2);
  localparam int  FRAC   = TW_W - 2;
  localparam int  PW     = DATA_W + TW_W + 1;
  localparam real PI     = 3.14159265358979323846;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  typedef logic signed [DATA_W-1:0] sample_t;

  state_t            state;
  logic [N_LOG2-1:0] cnt;
  logic [N_LOG2-1:0] out_idx;
  logic [N_LOG2-2:0] bfly;
  logic [S_W-1:0]    stage;
  logic              in_ready;
  logic              out_valid;
  logic              out_last;

  sample_t mem_re [N];
  sample_t mem_im [N];

  // Twiddle ROM, W[k] = exp(-j*2*pi*k/N), rounded half away from zero.
  logic signed [TW_W-1:0] rom_re [HALF_N];
  logic signed [TW_W-1:0] rom_im [HALF_N];

  for (genvar k = 0; k < HALF_N; k++) begin : g_tw
    localparam real ANG = 2.0 * PI * k / N;
    localparam real CR  = $cos(ANG) * (2.0 ** FRAC);
    localparam real CI  = -$sin(ANG) * (2.0 ** FRAC);
    localparam int  WR  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
    localparam int  WI  = (CI >= 0.0) ? $rtoi(CI + 0.5) : -$rtoi(0.5 - CI);
    assign rom_re[k] = TW_W'(WR);
    assign rom_im[k] = TW_W'(WI);
  end

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    for (int i = 0; i < N_LOG2; i++) bitrev[i] = v[N_LOG2-1-i];
  endfunction

  logic [N_LOG2-1:0] j_ext, half, pos, top, bot;
  logic [N_LOG2-2:0] tw;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    j_ext = {1'b0, bfly};
    half  = N_LOG2'(1) << stage;
    pos   = j_ext & (half - N_LOG2'(1));
    top   = ((j_ext >> stage) << stage << 1) + pos;
    bot   = top + half;
    tw    = (N_LOG2-1)'({pos, {(N_LOG2-1){1'b0}}} >> stage);
  end

  sample_t                a_re, a_im, b_re, b_im, t_re, t_im;
  sample_t                y0_re, y0_im, y1_re, y1_im;
  logic signed [TW_W-1:0] w_re, w_im;
  logic signed [PW-1:0]   p_re, p_im;

  always_comb begin
    a_re = mem_re[top];
    a_im = mem_im[top];
    b_re = mem_re[bot];
    b_im = mem_im[bot];
    w_re = rom_re[tw];
    w_im = rom_im[tw];
    p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    t_re = DATA_W'(p_re >>> FRAC);
    t_im = DATA_W'(p_im >>> FRAC);
`ifdef FFT_STAGE_SCALE_EN
    // One guard bit keeps the sum exact before the halving.
    y0_re = DATA_W'(((DATA_W+1)'(a_re) + (DATA_W+1)'(t_re)) >>> 1);
    y0_im = DATA_W'(((DATA_W+1)'(a_im) + (DATA_W+1)'(t_im)) >>> 1);
    y1_re = DATA_W'(((DATA_W+1)'(a_re) - (DATA_W+1)'(t_re)) >>> 1);
    y1_im = DATA_W'(((DATA_W+1)'(a_im) - (DATA_W+1)'(t_im)) >>> 1);
`else
    y0_re = a_re + t_re;
    y0_im = a_im + t_im;
    y1_re = a_re - t_re;
    y1_im = a_im - t_im;
`endif
  end

  // NOTE: the sample buffer is plain storage and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && bus.in_valid && in_ready) begin
      mem_re[bitrev(cnt)] <= bus.in_re;
      mem_im[bitrev(cnt)] <= bus.in_im;
    end else if (!rst && state == COMPUTE) begin
      mem_re[top] <= y0_re;
      mem_im[top] <= y0_im;
      mem_re[bot] <= y1_re;
      mem_im[bot] <= y1_im;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      bfly      <= '0;
      stage     <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid && in_ready) begin
            cnt <= cnt + N_LOG2'(1);
            if (&cnt) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          bfly <= bfly + (N_LOG2-1)'(1);
          if (&bfly) begin
            stage <= stage + S_W'(1);
            if (stage == S_W'(N_LOG2 - 1)) begin
              stage     <= '0;
              state     <= UNLOAD;
              out_valid <= 1'b1;
            end
          end
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            if (out_last) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_idx  <= out_idx + N_LOG2'(1);
              out_last <= (out_idx == N_LOG2'(N - 2));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_idx   = out_idx;
  assign bus.out_re    = out_valid ? mem_re[out_idx] : '0;
  assign bus.out_im    = out_valid ? mem_im[out_idx] : '0;
endmodule

// File: doc/fft_r2_iter.md
Name: fft_r2_iter

Overview:
- Parametrised, sequential successor to the combinational 16-point FFT (sixtnpt).
- Computes an N-point radix-2 DIT complex FFT, N = 2^N_LOG2, using one in-place butterfly per clock over an internal register-array buffer.
- Samples stream in and out over valid/ready handshakes.
- Sits between the sample front-end and the spectral post-processing, replacing the fixed flat-bus 16-point core.

Parameters:
- N_LOG2, 4, log2 of transform size. N = 2^N_LOG2; legal range 2..10.
- DATA_W, 32, signed two's-complement width of each real/imag sample. Q16.16 at the default width.
- TW_W, 18, signed twiddle width. Fraction bits = TW_W-2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts an input sample.
- in_re  in  DATA_W  input real part.
- in_im  in  DATA_W  input imaginary part.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the output bin.
- out_re  out  DATA_W  bin real part.
- out_im  out  DATA_W  bin imaginary part.
- out_idx  out  N_LOG2  bin index of the current output.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (state LOAD, all counters 0): in_ready=1, out_valid=0, out_last=0, out_idx=0, busy=0, out_re=out_im=0. Buffer contents are not reset.
- Reset mid-operation: aborts the frame and returns to LOAD; partial data is discarded.
- State LOAD:
  - in_ready=1.
  - On in_valid&in_ready, sample k (k = accepted count) is written to buffer[bitrev(k)].
  - Cycles with in_valid low do not advance k.
  - On the Nth accept, go to COMPUTE next cycle.
- State COMPUTE:
  - in_ready=0, busy=1.
  - Counters: stage s = 0..N_LOG2-1, butterfly j = 0..N/2-1.
  - Addressing: half = 2^s; pos = j & (half-1); top = ((j>>s)<<(s+1)) + pos; bot = top + half; twiddle index tw = pos << (N_LOG2-1-s).
  - One butterfly per cycle: combinational read of buffer[top] and buffer[bot], write of both at the clock edge.
  - Butterfly: t = W[tw]*X[bot]; X[top] <= X[top]+t; X[bot] <= X[top]-t.
  - Last butterfly of the last stage goes to UNLOAD.
  - Compute time: exactly (N/2)*N_LOG2 cycles (32 for N=16).
- Twiddle ROM, N/2 entries, built at elaboration:
  - W_re[k] = round(cos(2πk/N)*2^(TW_W-2)).
  - W_im[k] = round(-sin(2πk/N)*2^(TW_W-2)).
- Complex multiply:
  - t_re = (a_re*w_re - a_im*w_im) >>> (TW_W-2); t_im = (a_re*w_im + a_im*w_re) >>> (TW_W-2).
  - Products and sums are full width; arithmetic shift (floor); keep DATA_W LSBs.
- Adds/subtracts wrap modulo 2^DATA_W, with no saturation.
- State UNLOAD:
  - out_valid=1, busy=1.
  - out_re/out_im = buffer[out_idx], natural order; out_last = (out_idx==N-1).
  - On out_valid&out_ready, out_idx increments. Data and index stay stable while out_ready is low.
  - Handshake of bin N-1: next cycle state=LOAD, out_valid=0, out_idx=0, in_ready=1.
- No overlap: input and output phases never run concurrently.

Optional Feature:
- Macro: FFT_STAGE_SCALE_EN.
- Defined: both butterfly results are arithmetic-shifted right by 1 before write-back, giving an overall 1/N scale; intermediate values cannot overflow for inputs within range.
- Undefined: unscaled, wrapping arithmetic as above.

Test Plan:
- Impulse, x[0]=0x0001_0000 and others 0, N=16:
  - Macro off: all 16 bins re=0x0001_0000, im=0.
  - Macro on: all bins re=0x0000_1000, im=0.
- DC, all 16 inputs re=0x0001_0000, im=0: X[0].re=0x0010_0000; all other bins and all imaginary parts 0. out_valid rises 32 cycles after the last input accept.
- Pair x[0]=0x0011_0000, x[1]=0x1000_0000, rest 0, macro off:
  - X[0].re=0x1011_0000.
  - X[8].re=0xF011_0000.
  - X[4].re=0x0011_0000, X[4].im=0xF000_0000.
- Backpressure and input gaps:
  - out_ready low 5 cycles at out_idx=3: out_idx, out_re and out_im stay constant.
  - in_valid low every other cycle: still exactly 16 accepts, with correct results.
- Reset mid-frame:
  - rst high for 1 cycle during COMPUTE, stage 2: next cycle in_ready=1, busy=0, out_valid=0.
  - A following impulse frame then produces correct results.
- Parameter sweep, N_LOG2=2 and 6: impulse and DC results are correct. Compute time is 4 and 192 cycles respectively; out_last is high only at idx N-1.
